// File: rtl/sprite_update_scheduler_if.sv
// Host-side and datapath-side signal bundle for sprite_update_scheduler.
//   master: host register writes, VGA line count, datapath ready (driver side)
//   slave : the scheduler; drives the update beat and status outputs
//   chipselect/write/address/writedata : host register write port
//   vcount                             : current VGA line
//   upd_valid/upd_ready/upd_addr/upd_data : update beat handshake
//   busy/overrun/frame_tick/anim_state : status outputs
interface sprite_update_scheduler_if #(
  parameter int unsigned ADDR_W = 9
) ();
  logic              chipselect;
  logic              write;
  logic [ADDR_W-1:0] address;
  logic [7:0]        writedata;
  logic [9:0]        vcount;
  logic              upd_valid;
  logic              upd_ready;
  logic [ADDR_W-1:0] upd_addr;
  logic [7:0]        upd_data;
  logic              busy;
  logic              overrun;
  logic              frame_tick;
  logic [1:0]        anim_state;

  modport master (
    output chipselect, write, address, writedata, vcount, upd_ready,
    input  upd_valid, upd_addr, upd_data, busy, overrun, frame_tick, anim_state
  );

  modport slave (
    input  chipselect, write, address, writedata, vcount, upd_ready,
    output upd_valid, upd_addr, upd_data, busy, overrun, frame_tick, anim_state
  );
endinterface

// File: rtl/sprite_update_scheduler.sv
// Shadow register file between the host and the sprite/score datapath.
// Host writes land in shadow registers and mark entries dirty; dirty entries
// are pushed to the datapath one per cycle during vertical blank only, so
// sprites never tear mid-frame. Also produces the per-frame tick and the
// dino walk-animation state.
// Ports:
//   clk   : system clock
//   reset : asynchronous, active-high
//   bus   : sprite_update_scheduler_if.slave (host write port, vcount,
//           update beat valid/ready/addr/data, busy, overrun, frame_tick,
//           anim_state)
// Build option: define SPRITE_SCHED_ANIM_EN to enable the walk-animation
// counter (ANIM_FRAMES / ANIM_STATES parameters); otherwise anim_state is 0.
module sprite_update_scheduler #(
  parameter int unsigned NREGS       = 16,
  parameter int unsigned ADDR_W      = 9,
  parameter int unsigned VACTIVE     = 480
`ifdef SPRITE_SCHED_ANIM_EN
  ,
  parameter int unsigned ANIM_FRAMES = 6,
  parameter int unsigned ANIM_STATES = 3
`endif
) (
  input logic                      clk,
  input logic                      reset,
  sprite_update_scheduler_if.slave bus
);
  localparam int unsigned IDX_W = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam int unsigned VC_W  = 10;
  localparam int unsigned D_W   = 8;

  typedef enum logic {ST_IDLE, ST_SCAN} state_t;

  state_t                      state_q, state_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic [NREGS-1:0]            dirty_q, dirty_d;
  logic [NREGS-1:0][D_W-1:0]   shadow_q, shadow_d;
  logic [VC_W-1:0]             vcount_q;
  logic                        abort_q, abort_d;
  logic                        overrun_q, overrun_d;
  logic                        upd_valid_q, upd_valid_d;
  logic [ADDR_W-1:0]           upd_addr_q, upd_addr_d;
  logic [D_W-1:0]              upd_data_q, upd_data_d;
  logic                        busy_q, busy_d;
  logic                        frame_tick_q;

  logic             wr_reg_c;
  logic             wr_ovr_clr_c;
  logic [IDX_W-1:0] waddr_c;
  logic             vblank_start_c;
  logic             line0_c;
  logic             accept_c;
  logic             load_c;

  // Host decode, blanking edge detect and handshake
  always_comb begin
    wr_reg_c       = bus.chipselect && bus.write && (bus.address < ADDR_W'(NREGS));
    wr_ovr_clr_c   = bus.chipselect && bus.write && (bus.address == ADDR_W'(NREGS));
    waddr_c        = bus.address[IDX_W-1:0];
    vblank_start_c = (bus.vcount == VC_W'(VACTIVE)) && (vcount_q != VC_W'(VACTIVE));
    line0_c        = (bus.vcount == '0);
    accept_c       = upd_valid_q && bus.upd_ready;
  end

  // Shadow/dirty update, scan sequencing and next beat registers
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    dirty_d    = dirty_q;
    shadow_d   = shadow_q;
    abort_d    = abort_q;
    overrun_d  = overrun_q;
    upd_valid_d = upd_valid_q;
    upd_addr_d  = upd_addr_q;
    upd_data_d  = upd_data_q;
    load_c     = 1'b0;

    // A host write landing on the entry being accepted re-dirties it, so
    // the set is applied after the clear.
    if (accept_c) begin
      dirty_d[idx_q] = 1'b0;
    end
    if (wr_reg_c) begin
      shadow_d[waddr_c] = bus.writedata;
      dirty_d[waddr_c]  = 1'b1;
    end
    if (wr_ovr_clr_c) begin
      overrun_d = 1'b0;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (vblank_start_c && (|dirty_q)) begin
          state_d = ST_SCAN;
          idx_d   = '0;
          abort_d = 1'b0;
          load_c  = 1'b1;
        end
      end
      ST_SCAN: begin
        if (line0_c) begin
          abort_d   = 1'b1;
          overrun_d = 1'b1;
        end
        // Entry boundary: current entry was clean or its beat was taken
        if (!upd_valid_q || accept_c) begin
          if ((idx_q == IDX_W'(NREGS - 1)) || abort_q || line0_c) begin
            state_d = ST_IDLE;
            abort_d = 1'b0;
          end else begin
            idx_d  = idx_q + IDX_W'(1);
            load_c = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Beat registers reload only on a new entry, so a stalled beat keeps its
    // data even if the host rewrites that entry meanwhile.
    if (load_c) begin
      upd_valid_d = dirty_d[idx_d];
      upd_addr_d  = ADDR_W'(idx_d);
      upd_data_d  = shadow_d[idx_d];
    end else if (state_d == ST_IDLE) begin
      upd_valid_d = 1'b0;
      upd_addr_d  = '0;
      upd_data_d  = '0;
    end

    busy_d = (state_d == ST_SCAN);
  end

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      dirty_q      <= '0;
      shadow_q     <= '0;
      vcount_q     <= '0;
      abort_q      <= 1'b0;
      overrun_q    <= 1'b0;
      upd_valid_q  <= 1'b0;
      upd_addr_q   <= '0;
      upd_data_q   <= '0;
      busy_q       <= 1'b0;
      frame_tick_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      dirty_q      <= dirty_d;
      shadow_q     <= shadow_d;
      vcount_q     <= bus.vcount;
      abort_q      <= abort_d;
      overrun_q    <= overrun_d;
      upd_valid_q  <= upd_valid_d;
      upd_addr_q   <= upd_addr_d;
      upd_data_q   <= upd_data_d;
      busy_q       <= busy_d;
      frame_tick_q <= vblank_start_c;
    end
  end

  assign bus.upd_valid  = upd_valid_q;
  assign bus.upd_addr   = upd_addr_q;
  assign bus.upd_data   = upd_data_q;
  assign bus.busy       = busy_q;
  assign bus.overrun    = overrun_q;
  assign bus.frame_tick = frame_tick_q;

`ifdef SPRITE_SCHED_ANIM_EN
  localparam int unsigned FC_W = (ANIM_FRAMES > 1) ? $clog2(ANIM_FRAMES) : 1;

  logic [FC_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [1:0]      anim_q, anim_d;

  // Walk animation: advance one state every ANIM_FRAMES frame ticks
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    anim_d      = anim_q;
    if (frame_tick_q) begin
      if (frame_cnt_q == FC_W'(ANIM_FRAMES - 1)) begin
        frame_cnt_d = '0;
        anim_d      = (anim_q == 2'(ANIM_STATES - 1)) ? 2'd0 : anim_q + 2'd1;
      end else begin
        frame_cnt_d = frame_cnt_q + FC_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_cnt_q <= '0;
      anim_q      <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      anim_q      <= anim_d;
    end
  end

  assign bus.anim_state = anim_q;
`else
  assign bus.anim_state = 2'd0;
`endif
endmodule

// File: tb/tb_sprite_update_scheduler.sv
// Self-checking bench for sprite_update_scheduler: directed scenarios plus a
// randomized phase, all compared cycle by cycle against a behavioural model
// of the shadow file, dirty set and vblank commit scan.
module tb_sprite_update_scheduler;
  localparam int unsigned NR = 16;
  localparam int unsigned AF = 2;
  localparam int unsigned AS = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sprite_update_scheduler_if #(.ADDR_W(9)) bus ();

`ifdef SPRITE_SCHED_ANIM_EN
  sprite_update_scheduler #(.NREGS(NR), .ADDR_W(9), .VACTIVE(480),
                            .ANIM_FRAMES(AF), .ANIM_STATES(AS)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave));
  localparam bit ANIM_ON = 1'b1;
`else
  sprite_update_scheduler #(.NREGS(NR), .ADDR_W(9), .VACTIVE(480)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave));
  localparam bit ANIM_ON = 1'b0;
`endif

  // Reference model state
  logic [7:0] m_shadow [NR];
  bit         m_dirty  [NR];
  bit         m_scan, m_abort, m_ovr;
  int         m_pos;
  logic [9:0] m_vq;
  logic       e_valid;
  logic [8:0] e_addr;
  logic [7:0] e_data;
  logic       e_tick;
  int         n_ticks;

  int checks = 0;
  int errors = 0;
  int obs_beats = 0;
  int obs_busy = 0;
  logic [16:0] obs_last = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    foreach (m_shadow[i]) begin
      m_shadow[i] = '0;
      m_dirty[i]  = 1'b0;
    end
    m_scan = 0; m_abort = 0; m_ovr = 0; m_pos = 0; m_vq = '0;
    e_valid = 0; e_addr = '0; e_data = '0; e_tick = 0; n_ticks = 0;
  endtask

  task automatic model_load();
    e_valid = m_dirty[m_pos];
    e_addr  = 9'(m_pos);
    e_data  = m_shadow[m_pos];
  endtask

  // One clock edge of the behavioural model
  task automatic model_edge(input logic cs, input logic wr, input logic [8:0] a,
                            input logic [7:0] d, input logic [9:0] vc, input logic rdy);
    bit vbs, acc, anyd;
    vbs  = (vc == 10'd480) && (m_vq != 10'd480);
    m_vq = vc;
    anyd = 0;
    foreach (m_dirty[i]) anyd |= m_dirty[i];
    if (e_tick) n_ticks++;
    e_tick = vbs;
    acc = e_valid && rdy;
    if (acc) m_dirty[m_pos] = 0;
    if (cs && wr && a < NR) begin
      m_shadow[a] = d;
      m_dirty[a]  = 1;
    end
    if (cs && wr && a == NR) m_ovr = 0;
    if (m_scan) begin
      if (vc == 10'd0) begin
        m_ovr = 1;
        m_abort = 1;
      end
      if (!e_valid || acc) begin
        if (m_pos == NR - 1 || m_abort) begin
          m_scan = 0; e_valid = 0; e_addr = '0; e_data = '0;
        end else begin
          m_pos++;
          model_load();
        end
      end
    end else if (vbs && anyd) begin
      m_scan = 1; m_pos = 0; m_abort = 0;
      model_load();
    end
  endtask

  task automatic compare_all();
    int anim_exp;
    anim_exp = ANIM_ON ? (n_ticks / AF) % AS : 0;
    check("upd_valid",  bus.upd_valid,  e_valid);
    check("upd_addr",   bus.upd_addr,   e_addr);
    check("upd_data",   bus.upd_data,   e_data);
    check("busy",       bus.busy,       m_scan);
    check("overrun",    bus.overrun,    m_ovr);
    check("frame_tick", bus.frame_tick, e_tick);
    check("anim_state", bus.anim_state, anim_exp);
  endtask

  // Drive inputs for one cycle, clock, then compare against the model
  task automatic step(input logic cs, input logic wr, input logic [8:0] a,
                      input logic [7:0] d, input logic [9:0] vc, input logic rdy);
    bit obs_acc;
    bus.chipselect = cs; bus.write = wr; bus.address = a;
    bus.writedata = d; bus.vcount = vc; bus.upd_ready = rdy;
    obs_acc = bus.upd_valid && rdy;
    if (obs_acc) begin
      obs_beats++;
      obs_last = {bus.upd_addr, bus.upd_data};
    end
    @(posedge clk);
    model_edge(cs, wr, a, d, vc, rdy);
    #1;
    compare_all();
    if (bus.busy) obs_busy++;
  endtask

  task automatic idle(input logic [9:0] vc, input logic rdy);
    step(1'b0, 1'b0, 9'd0, 8'd0, vc, rdy);
  endtask

  task automatic hw(input logic [8:0] a, input logic [7:0] d, input logic [9:0] vc);
    step(1'b1, 1'b1, a, d, vc, 1'b0);
  endtask

  // Blanking start: line 479, then ncyc lines from 480 with ready low for
  // the first `stall` cycles after the scan starts
  task automatic vbl(input int ncyc, input int stall);
    idle(10'd479, 1'b0);
    for (int k = 0; k < ncyc; k++) idle(10'(480 + k), (k > stall));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_reset();
    compare_all();
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  int b0, busy0;
  int exp_anim [7];

  initial begin
    bus.chipselect = 0; bus.write = 0; bus.address = '0; bus.writedata = '0;
    bus.vcount = '0; bus.upd_ready = 0;
    reset = 1'b0;
    for (int i = 0; i < 7; i++) exp_anim[i] = 0;
    if (ANIM_ON) begin
      exp_anim[0] = 0; exp_anim[1] = 1; exp_anim[2] = 1; exp_anim[3] = 2;
      exp_anim[4] = 2; exp_anim[5] = 0; exp_anim[6] = 0;
    end
    @(posedge clk);
    #1;
    do_reset();
    for (int i = 0; i < 3; i++) idle(10'd100, 1'b0);

    // Animation sequence over 7 frames
    for (int f = 0; f < 7; f++) begin
      idle(10'd479, 1'b0);
      idle(10'd480, 1'b0);
      check("tick_pulse", bus.frame_tick, 1'b1);
      idle(10'd481, 1'b0);
      check("anim_seq", bus.anim_state, exp_anim[f]);
    end

    // Two dirty entries, ready high
    hw(9'd0, 8'd100, 10'd470);
    hw(9'd3, 8'd50, 10'd470);
    b0 = obs_beats; busy0 = obs_busy;
    vbl(20, 0);
    check("two_beats", obs_beats - b0, 2);
    check("busy_len", obs_busy - busy0, NR);
    check("last_beat", obs_last, {9'd3, 8'd50});

    // Same with a 5-cycle stall on the first beat
    hw(9'd0, 8'd100, 10'd470);
    hw(9'd3, 8'd50, 10'd470);
    b0 = obs_beats;
    vbl(25, 5);
    check("stall_beats", obs_beats - b0, 2);

    // Writes behind and ahead of the scan pointer
    hw(9'd0, 8'd1, 10'd470);
    b0 = obs_beats;
    idle(10'd479, 1'b1);
    idle(10'd480, 1'b1);
    idle(10'd481, 1'b1);
    step(1'b1, 1'b1, 9'd0, 8'd7, 10'd482, 1'b1);
    step(1'b1, 1'b1, 9'd9, 8'd20, 10'd483, 1'b1);
    for (int k = 0; k < 16; k++) idle(10'(484 + k), 1'b1);
    check("mid_scan_beats", obs_beats - b0, 2);
    check("mid_scan_last", obs_last, {9'd9, 8'd20});
    b0 = obs_beats;
    vbl(20, 0);
    check("carry_beats", obs_beats - b0, 1);
    check("carry_last", obs_last, {9'd0, 8'd7});

    // Overrun: all dirty, ready low, line wraps to 0
    for (int i = 0; i < 16; i++) hw(9'(i), 8'(8'hA0 + i), 10'd470);
    b0 = obs_beats;
    vbl(6, 100);
    idle(10'd0, 1'b0);
    check("overrun_set", bus.overrun, 1'b1);
    for (int k = 1; k < 4; k++) idle(10'(k), 1'b0);
    check("abort_hold", bus.upd_valid, 1'b1);
    idle(10'd4, 1'b1);
    idle(10'd5, 1'b1);
    check("abort_idle", bus.busy, 1'b0);
    check("abort_beats", obs_beats - b0, 1);
    b0 = obs_beats;
    vbl(20, 0);
    check("remainder_beats", obs_beats - b0, 15);
    hw(9'd16, 8'd0, 10'd470);
    check("overrun_clr", bus.overrun, 1'b0);

    // Reset in the middle of a scan discards dirty state
    for (int i = 0; i < 16; i++) hw(9'(i), 8'(i), 10'd470);
    vbl(4, 100);
    do_reset();
    b0 = obs_beats;
    vbl(20, 0);
    check("post_reset_beats", obs_beats - b0, 0);

    // Randomized traffic over compressed frames
    for (int c = 0; c < 1200; c++) begin
      int pos;
      logic [9:0] vc;
      pos = c % 40;
      vc = (pos < 30) ? 10'(470 + pos) : 10'(pos - 30);
      if ($urandom_range(0, 9) < 4)
        step(1'b1, 1'($urandom_range(0, 3) != 0), 9'($urandom_range(0, 18)),
             8'($urandom), vc, 1'($urandom_range(0, 9) < 7));
      else
        idle(vc, 1'($urandom_range(0, 9) < 7));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
